// File: rtl/ads_frame_capture.sv
// ADS conversion-frame reader: on each DRDY event, shifts in status plus NUM_CH samples over SPI (CPOL=0).
// Streams each word as a 32-bit AXI-stream beat and keeps frame/overrun counters for the register block.
module ads_frame_capture #(
    parameter int CLK_DIV  = 4,
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 24
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        drdy_n,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [15:0] overrun_cnt
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST  = 5'(SAMPLE_W - 1);
    localparam logic [3:0] WORD_LAST = 4'(NUM_CH);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic [4:0]    bit_q, bit_d;
    logic [3:0]    word_q, word_d;
    logic [23:0]   shift_q, shift_d;
    logic          done_q, done_d;
    logic [3:0]    done_idx_q, done_idx_d;
    logic [31:0]   tdata_q, tdata_d;
    logic [3:0]    tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   ovr_q, ovr_d;
    logic          sync1_q, sync2_q, sync3_q;

    logic          div_end;
    logic          drdy_evt;
    logic          out_load;
    logic          word_drop;
    logic          drdy_missed;
    logic [1:0]    ovr_inc;
    logic [16:0]   ovr_sum;

    // Two flops synchronise drdy_n; the third only remembers the previous synchronised value.
    assign drdy_evt = sync3_q & ~sync2_q;
    assign div_end  = (div_q == DIV_LAST);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            bit_q       <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            done_idx_q  <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            frame_cnt_q <= '0;
            ovr_q       <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            done_idx_q  <= done_idx_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_q       <= ovr_d;
            sync1_q     <= drdy_n;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        bit_d       = bit_q;
        word_d      = word_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        done_idx_d  = done_idx_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (drdy_evt && enable) begin
                    state_d = CS_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    sclk_d  = 1'b0;
                end
            end
            CS_SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Sample on the falling edge: the ADS updates DOUT on the rising edge.
                    if (sclk_q) begin
                        shift_d = {shift_q[22:0], spi_miso};
                        if (bit_q == BIT_LAST) begin
                            bit_d      = '0;
                            done_d     = 1'b1;
                            done_idx_d = word_q;
                            word_d     = word_q + 4'd1;
                            if (word_q == WORD_LAST) begin
                                state_d = CS_HOLD;
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            CS_HOLD: begin
                if (div_end) begin
                    div_d       = '0;
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = (state_d == IDLE);
    end

    // A completed word is accepted only if the output slot is empty or draining this cycle.
    assign out_load    = done_q && (!tvalid_q || m_tready);
    assign word_drop   = done_q && tvalid_q && !m_tready;
    assign drdy_missed = drdy_evt && (state_q != IDLE);
    assign ovr_inc     = {1'b0, word_drop} + {1'b0, drdy_missed};
    assign ovr_sum     = {1'b0, ovr_q} + {15'd0, ovr_inc};

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
        if (out_load) begin
            tvalid_d = 1'b1;
            tdata_d  = (done_idx_q == 4'd0) ? {8'h00, shift_q} : {{8{shift_q[23]}}, shift_q};
            tuser_d  = done_idx_q;
            tlast_d  = (done_idx_q == WORD_LAST);
        end
        ovr_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end

    assign spi_sclk    = sclk_q;
    assign spi_mosi    = 1'b0;
    assign spi_cs_n    = cs_n_q;
    assign busy        = ~cs_n_q;
    assign m_tdata     = tdata_q;
    assign m_tuser     = tuser_q;
    assign m_tlast     = tlast_q;
    assign m_tvalid    = tvalid_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_ads_frame_capture.sv
// Directed bench for ads_frame_capture: ADS DOUT model, stream monitor and step-by-step checks.
module tb_ads_frame_capture;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        enable;
    logic        drdy_n;
    logic        spi_miso;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [31:0] m_tdata;
    logic [3:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic [31:0] frame_cnt;
    logic [15:0] overrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    ads_frame_capture #(.CLK_DIV(4), .NUM_CH(8), .SAMPLE_W(24)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .drdy_n(drdy_n),
        .spi_miso(spi_miso), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .busy(busy), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    // ADS model: presents the frame MSB first, advancing one bit per falling SCLK edge.
    logic [215:0] ads_frame;
    int           bit_idx = 0;

    always @(negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) bit_idx = 0;
        else          bit_idx = bit_idx + 1;
    end

    assign spi_miso = (bit_idx < 216) ? ads_frame[215 - bit_idx] : 1'b0;

    // Stream and SPI activity monitor, sampled on the falling ACLK edge.
    logic [31:0] q_data[$];
    logic [3:0]  q_user[$];
    logic        q_last[$];
    int          cs_low_cycles = 0;
    int          sclk_rises    = 0;
    logic        sclk_prev     = 1'b0;

    always @(negedge ACLK) begin
        if (ARESETN && m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_user.push_back(m_tuser);
            q_last.push_back(m_tlast);
        end
        if (!spi_cs_n) cs_low_cycles = cs_low_cycles + 1;
        if (spi_sclk && !sclk_prev) sclk_rises = sclk_rises + 1;
        sclk_prev = spi_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic load_frame(input logic [23:0] st, input logic [23:0] ch [8]);
        ads_frame[215 -: 24] = st;
        for (int k = 0; k < 8; k++) ads_frame[191 - 24 * k -: 24] = ch[k];
    endtask

    task automatic pulse_drdy();
        drdy_n = 1'b0;
        tick(6);
        drdy_n = 1'b1;
        tick(2);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        tick(3);
        ARESETN = 1'b1;
        tick(2);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy && c < limit) begin
            tick(1);
            c++;
        end
        chk("idle_after_frame", 32'(busy), 32'd0);
    endtask

    // Nominal frame: status 0xC00000, channel k = k.
    task automatic check_nominal(input string tag, input int base);
        logic [31:0] exp;
        chk({tag, "_count"}, 32'(q_data.size() - base), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (base + k < q_data.size()) begin
                exp = (k == 0) ? 32'h00C0_0000 : 32'(k);
                chk($sformatf("%s_data%0d", tag, k), q_data[base + k], exp);
                chk($sformatf("%s_user%0d", tag, k), 32'(q_user[base + k]), 32'(k));
                chk($sformatf("%s_last%0d", tag, k), 32'(q_last[base + k]), 32'(k == 8));
            end
        end
    endtask

    logic [23:0] nom_ch [8];
    logic [23:0] sx_ch  [8];

    initial begin
        int base;
        int cs0;
        int r0;

        nom_ch = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
                   24'h000005, 24'h000006, 24'h000007, 24'h000008};
        sx_ch  = '{24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000000,
                   24'h000000, 24'h000000, 24'h000000, 24'h000000};
        ARESETN  = 1'b0;
        enable   = 1'b0;
        drdy_n   = 1'b1;
        m_tready = 1'b1;
        load_frame(24'hC00000, nom_ch);
        tick(3);

        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        ARESETN = 1'b1;
        tick(2);

        // Nominal frame
        enable = 1'b1;
        base = q_data.size();
        cs0  = cs_low_cycles;
        r0   = sclk_rises;
        pulse_drdy();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_idle(4000);
        check_nominal("t1", base);
        chk("t1_frame_cnt", frame_cnt, 32'd1);
        chk("t1_overrun", 32'(overrun_cnt), 32'd0);
        chk("t1_cs_low_cycles", 32'(cs_low_cycles - cs0), 32'd1736);
        chk("t1_sclk_rises", 32'(sclk_rises - r0), 32'd216);
        chk("t1_sclk_end", 32'(spi_sclk), 32'd0);
        chk("t1_cs_n_end", 32'(spi_cs_n), 32'd1);

        // Sign extension
        load_frame(24'hFFFFFF, sx_ch);
        base = q_data.size();
        pulse_drdy();
        wait_idle(4000);
        chk("t2_count", 32'(q_data.size() - base), 32'd9);
        if (q_data.size() - base >= 4) begin
            chk("t2_status", q_data[base], 32'h00FF_FFFF);
            chk("t2_ch1", q_data[base + 1], 32'hFF80_0000);
            chk("t2_ch2", q_data[base + 2], 32'h007F_FFFF);
            chk("t2_ch3", q_data[base + 3], 32'hFFFF_FFFF);
        end
        chk("t2_frame_cnt", frame_cnt, 32'd2);

        // Backpressure for a whole frame
        load_frame(24'hC00000, nom_ch);
        do_reset();
        m_tready = 1'b0;
        base = q_data.size();
        pulse_drdy();
        wait_idle(4000);
        tick(2);
        chk("t3_overrun", 32'(overrun_cnt), 32'd8);
        chk("t3_tvalid_held", 32'(m_tvalid), 32'd1);
        chk("t3_tuser_held", 32'(m_tuser), 32'd0);
        chk("t3_tdata_held", m_tdata, 32'h00C0_0000);
        chk("t3_none_out", 32'(q_data.size() - base), 32'd0);
        m_tready = 1'b1;
        tick(1);
        chk("t3_one_out", 32'(q_data.size() - base), 32'd1);
        if (q_data.size() > base) begin
            chk("t3_out_data", q_data[base], 32'h00C0_0000);
            chk("t3_out_user", 32'(q_user[base]), 32'd0);
        end
        tick(1);
        chk("t3_tvalid_clear", 32'(m_tvalid), 32'd0);

        // DRDY while busy
        do_reset();
        base = q_data.size();
        pulse_drdy();
        tick(500);
        pulse_drdy();
        wait_idle(4000);
        check_nominal("t4", base);
        chk("t4_overrun", 32'(overrun_cnt), 32'd1);
        chk("t4_frame_cnt", frame_cnt, 32'd1);

        // Reset during word 3
        pulse_drdy();
        tick(700);
        ARESETN = 1'b0;
        #1;
        chk("t5_cs_n_async", 32'(spi_cs_n), 32'd1);
        chk("t5_sclk_async", 32'(spi_sclk), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_tvalid_async", 32'(m_tvalid), 32'd0);
        chk("t5_frame_cnt_async", frame_cnt, 32'd0);
        chk("t5_overrun_async", 32'(overrun_cnt), 32'd0);
        tick(2);
        ARESETN = 1'b1;
        tick(2);
        base = q_data.size();
        pulse_drdy();
        wait_idle(4000);
        check_nominal("t5", base);
        chk("t5_frame_cnt", frame_cnt, 32'd1);

        // Enable gating
        enable = 1'b0;
        cs0 = cs_low_cycles;
        r0  = sclk_rises;
        pulse_drdy();
        tick(50);
        chk("t6_no_cs", 32'(cs_low_cycles - cs0), 32'd0);
        chk("t6_no_sclk", 32'(sclk_rises - r0), 32'd0);
        chk("t6_frame_cnt_gated", frame_cnt, 32'd1);
        chk("t6_overrun_gated", 32'(overrun_cnt), 32'd0);
        enable = 1'b1;
        base = q_data.size();
        pulse_drdy();
        tick(200);
        enable = 1'b0;
        wait_idle(4000);
        check_nominal("t6", base);
        chk("t6_frame_cnt", frame_cnt, 32'd2);
        tick(50);
        chk("t6_stays_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
